branch_predict_unit: RTL and testbench

//  Parametrised branch resolve-and-predict unit for the 5-stage MIPS pipeline.

---
 rtl/branch_predict_unit.sv | 117 +++++++++++
 tb/tb_branch_predict_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolve-and-predict unit: PC-indexed saturating counter table,
// EX-stage branch resolution, mispredict flagging and statistics.
module branch_predict_unit #(
    parameter int IDX_W    = 6,
    parameter int CNT_W    = 2,
    parameter int INIT_CNT = 1,
    parameter int STAT_W   = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [31:0]       PCIf,
    output logic              PredTakenIf,
    input  logic [31:0]       InstrEx,
    input  logic [31:0]       PCEx,
    input  logic [31:0]       ALURstEx,
    input  logic              ZeroEx,
    input  logic              PredTakenEx,
    input  logic              ValidEx,
    input  logic              StallEx,
    output logic              IsBranchEx,
    output logic              BranchEx,
    output logic              MispredictEx,
    output logic [STAT_W-1:0] BrCount,
    output logic [STAT_W-1:0] MissCount
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MIN  = '0;

    logic [CNT_W-1:0] cntTable [DEPTH];
    logic [IDX_W-1:0] idxIf;
    logic [IDX_W-1:0] idxEx;
    logic [5:0]       opcode;
    logic [4:0]       rt;
    logic             ltFlag;
    logic             update;
    logic [CNT_W-1:0] cntCur;
    logic [CNT_W-1:0] cntNext;
    logic             unusedBits;

    assign idxIf  = PCIf[IDX_W+1:2];
    assign idxEx  = PCEx[IDX_W+1:2];
    assign opcode = InstrEx[31:26];
    assign rt     = InstrEx[20:16];
    assign ltFlag = ALURstEx[0];

    assign unusedBits = ^{PCIf[31:IDX_W+2], PCIf[1:0],
                          PCEx[31:IDX_W+2], PCEx[1:0],
                          InstrEx[25:21], InstrEx[15:0],
                          ALURstEx[31:1]};

    always_comb begin
        IsBranchEx = 1'b0;
        BranchEx   = 1'b0;
        case (opcode)
            6'b000001: begin
                if (rt == 5'b00000) begin
                    IsBranchEx = 1'b1;
                    BranchEx   = ltFlag;
                end else if (rt == 5'b00001) begin
                    IsBranchEx = 1'b1;
                    BranchEx   = !ltFlag;
                end
            end
            6'b000100: begin
                IsBranchEx = 1'b1;
                BranchEx   = ZeroEx;
            end
            6'b000101: begin
                IsBranchEx = 1'b1;
                BranchEx   = !ZeroEx;
            end
            6'b000110: begin
                IsBranchEx = 1'b1;
                BranchEx   = ltFlag | ZeroEx;
            end
            6'b000111: begin
                IsBranchEx = 1'b1;
                BranchEx   = !(ltFlag | ZeroEx);
            end
            default: ;
        endcase
    end

    // IF reads registered state only, so a same-cycle EX write is seen next cycle
    assign PredTakenIf  = cntTable[idxIf][CNT_W-1];
    assign MispredictEx = !Rst & IsBranchEx & ValidEx & (BranchEx != PredTakenEx);
    assign update       = IsBranchEx & ValidEx & !StallEx & !Rst;
    assign cntCur       = cntTable[idxEx];

    always_comb begin
        cntNext = cntCur;
        if (BranchEx) begin
            if (cntCur != CNT_MAX) cntNext = cntCur + 1'b1;
        end else begin
            if (cntCur != CNT_MIN) cntNext = cntCur - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cntTable[i] <= CNT_INIT;
            end
            BrCount   <= '0;
            MissCount <= '0;
        end else if (update) begin
            cntTable[idxEx] <= cntNext;
            if (BrCount != {STAT_W{1'b1}}) BrCount <= BrCount + 1'b1;
            if (MispredictEx && (MissCount != {STAT_W{1'b1}}))
                MissCount <= MissCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; expectations go through a
// queue scoreboard and are checked with immediate assertions.
module tb_branch_predict_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] PCIf;
    logic        PredTakenIf;
    logic [31:0] InstrEx;
    logic [31:0] PCEx;
    logic [31:0] ALURstEx;
    logic        ZeroEx;
    logic        PredTakenEx;
    logic        ValidEx;
    logic        StallEx;
    logic        IsBranchEx;
    logic        BranchEx;
    logic        MispredictEx;
    logic [15:0] BrCount;
    logic [15:0] MissCount;

    localparam logic [31:0] BEQ  = 32'h1000_0000;
    localparam logic [31:0] BNE  = 32'h1400_0000;
    localparam logic [31:0] BLEZ = 32'h1800_0000;
    localparam logic [31:0] BGTZ = 32'h1C00_0000;
    localparam logic [31:0] BLTZ = 32'h0400_0000;
    localparam logic [31:0] BGEZ = 32'h0401_0000;
    localparam logic [31:0] RIM2 = 32'h0402_0000;
    localparam logic [31:0] LW   = 32'h8C00_0000;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   nRun = 0;
    int   nFail = 0;
    int   expBr = 0;
    int   expMiss = 0;

    always #5 Clk = ~Clk;

    branch_predict_unit dut (
        .Clk(Clk), .Rst(Rst), .PCIf(PCIf), .PredTakenIf(PredTakenIf),
        .InstrEx(InstrEx), .PCEx(PCEx), .ALURstEx(ALURstEx),
        .ZeroEx(ZeroEx), .PredTakenEx(PredTakenEx), .ValidEx(ValidEx),
        .StallEx(StallEx), .IsBranchEx(IsBranchEx), .BranchEx(BranchEx),
        .MispredictEx(MispredictEx), .BrCount(BrCount),
        .MissCount(MissCount)
    );

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [31:0] obs);
        exp_t e;
        nRun++;
        if (sb.size() == 0) begin
            nFail++;
            $error("FAIL scoreboard-empty got=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                nFail++;
                $error("FAIL %s got=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ValidEx = 1'b0;
        StallEx = 1'b0;
        InstrEx = 32'h0;
    endtask

    task automatic predChk(input logic [31:0] pc, input logic e,
                           input string tag);
        PCIf = pc;
        push(tag, {31'b0, e});
        #1;
        pop({31'b0, PredTakenIf});
    endtask

    task automatic statChk(input string tag);
        push({tag, " brcnt"}, expBr);
        push({tag, " misscnt"}, expMiss);
        pop({16'b0, BrCount});
        pop({16'b0, MissCount});
    endtask

    // One EX cycle with ValidEx=1; then advance past the edge
    task automatic br(input logic [31:0] instr, input logic [31:0] pc,
                      input logic a0, input logic z, input logic pe,
                      input logic st, input logic eIs, input logic eTk,
                      input logic [31:0] pcIf, input logic ePred,
                      input string tag);
        logic eMis;
        InstrEx     = instr;
        PCEx        = pc;
        ALURstEx    = {31'b0, a0};
        ZeroEx      = z;
        PredTakenEx = pe;
        ValidEx     = 1'b1;
        StallEx     = st;
        PCIf        = pcIf;
        eMis        = eIs && (eTk != pe);
        push({tag, " isbr"}, {31'b0, eIs});
        push({tag, " taken"}, {31'b0, eTk});
        push({tag, " misp"}, {31'b0, eMis});
        push({tag, " pred"}, {31'b0, ePred});
        #1;
        pop({31'b0, IsBranchEx});
        pop({31'b0, BranchEx});
        pop({31'b0, MispredictEx});
        pop({31'b0, PredTakenIf});
        if (eIs && !st) begin
            expBr++;
            if (eMis) expMiss++;
        end
        tick();
    endtask

    // Decode-only probe with ValidEx=0: no training, no mispredict
    task automatic dec(input logic [31:0] instr, input logic a0,
                       input logic z, input logic eIs, input logic eTk,
                       input string tag);
        InstrEx     = instr;
        ALURstEx    = {31'b0, a0};
        ZeroEx      = z;
        PredTakenEx = 1'b0;
        ValidEx     = 1'b0;
        push({tag, " isbr"}, {31'b0, eIs});
        push({tag, " taken"}, {31'b0, eTk});
        push({tag, " misp"}, 32'h0);
        #1;
        pop({31'b0, IsBranchEx});
        pop({31'b0, BranchEx});
        pop({31'b0, MispredictEx});
        tick();
    endtask

    initial begin
        Rst = 1'b1;
        PCIf = 32'h0;
        PCEx = 32'h0;
        ALURstEx = 32'h0;
        ZeroEx = 1'b0;
        PredTakenEx = 1'b0;
        idle();
        repeat (2) tick();
        Rst = 1'b0;

        predChk(32'h40, 1'b0, "rst pred40");
        predChk(32'h1FC, 1'b0, "rst pred1fc");
        statChk("rst");

        // Taken BEQ x3 at 0x40: 1 -> 2 -> 3 -> 3
        br(BEQ, 32'h40, 0, 1, 0, 0, 1, 1, 32'h40, 0, "beq1");
        br(BEQ, 32'h40, 0, 1, 1, 0, 1, 1, 32'h40, 1, "beq2");
        br(BEQ, 32'h40, 0, 1, 1, 0, 1, 1, 32'h40, 1, "beq3");
        idle();
        predChk(32'h40, 1'b1, "beq sat pred");
        statChk("beq x3");
        // Not-taken walk down to floor: 3 -> 2 -> 1 -> 0 -> 0, then up 0 -> 1 -> 2
        br(BEQ, 32'h40, 0, 0, 1, 0, 1, 0, 32'h40, 1, "beqN1");
        br(BEQ, 32'h40, 0, 0, 1, 0, 1, 0, 32'h40, 1, "beqN2");
        br(BEQ, 32'h40, 0, 0, 0, 0, 1, 0, 32'h40, 0, "beqN3");
        br(BEQ, 32'h40, 0, 0, 0, 0, 1, 0, 32'h40, 0, "beqN4");
        br(BEQ, 32'h40, 0, 1, 0, 0, 1, 1, 32'h40, 0, "beqT4");
        br(BEQ, 32'h40, 0, 1, 0, 0, 1, 1, 32'h40, 0, "beqT5");
        idle();
        predChk(32'h40, 1'b1, "floor sat pred");
        statChk("beq walk");

        for (int k = 0; k < 4; k++) begin
            logic a0;
            logic z;
            a0 = k[0];
            z  = k[1];
            dec(BLTZ, a0, z, 1, a0, "bltz");
            dec(BGEZ, a0, z, 1, !a0, "bgez");
            dec(BLEZ, a0, z, 1, a0 | z, "blez");
            dec(BGTZ, a0, z, 1, !(a0 | z), "bgtz");
            dec(BEQ, a0, z, 1, z, "beq");
            dec(BNE, a0, z, 1, !z, "bne");
        end
        dec(RIM2, 1, 1, 0, 0, "regimm rt2");
        dec(LW, 1, 1, 0, 0, "lw");

        br(RIM2, 32'h100, 1, 0, 0, 0, 0, 0, 32'h100, 0, "rimm2 valid");
        br(LW, 32'h100, 1, 1, 0, 0, 0, 0, 32'h100, 0, "lw valid");
        idle();
        predChk(32'h100, 1'b0, "non-branch no train");
        statChk("non-branch");

        // BNE taken held 4 stall cycles then released: 1 -> 2 once
        for (int s = 0; s < 4; s++) begin
            br(BNE, 32'hC0, 0, 0, 0, 1, 1, 1, 32'hC0, 0, "bne stall");
            statChk("bne stall");
        end
        br(BNE, 32'hC0, 0, 0, 0, 0, 1, 1, 32'hC0, 0, "bne go");
        idle();
        predChk(32'hC0, 1'b1, "bne after release");
        statChk("bne released");
        br(BNE, 32'hC0, 0, 1, 1, 0, 1, 0, 32'hC0, 1, "bne nt");
        idle();
        predChk(32'hC0, 1'b0, "bne single step");

        // Same-index read/write and aliasing at 0x80 / 0x180
        br(BEQ, 32'h80, 0, 1, 0, 0, 1, 1, 32'h80, 0, "same idx old");
        idle();
        predChk(32'h80, 1'b1, "same idx new");
        predChk(32'h83, 1'b1, "pc low bits");
        predChk(32'h180, 1'b1, "alias read");
        br(BEQ, 32'h180, 0, 0, 1, 0, 1, 0, 32'h80, 1, "alias train");
        idle();
        predChk(32'h80, 1'b0, "alias trained");
        statChk("pre rst");

        // Reset coincident with a taken BEQ at 0x40 (entry currently 2)
        Rst         = 1'b1;
        InstrEx     = BEQ;
        PCEx        = 32'h40;
        ALURstEx    = 32'h0;
        ZeroEx      = 1'b1;
        PredTakenEx = 1'b0;
        ValidEx     = 1'b1;
        StallEx     = 1'b0;
        PCIf        = 32'h40;
        push("rst misp", 32'h0);
        push("rst cycle pred", 32'h1);
        #1;
        pop({31'b0, MispredictEx});
        pop({31'b0, PredTakenIf});
        tick();
        Rst = 1'b0;
        idle();
        expBr   = 0;
        expMiss = 0;
        predChk(32'h40, 1'b0, "post rst pred40");
        statChk("post rst");
        br(BEQ, 32'h40, 0, 1, 0, 0, 1, 1, 32'h40, 0, "init cnt");
        idle();
        predChk(32'h40, 1'b1, "init cnt step");
        statChk("final");

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
